// File: rtl/data_ram_pkg.sv
// Shared datapath constants for the data memory, the datapath and the ALU-result
// address slice that feeds it.
package data_ram_pkg;

  localparam int DATA_W     = 32;
  localparam int RAM_ADDR_W = 10;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [RAM_ADDR_W-1:0] waddr_t;

endpackage : data_ram_pkg

// File: rtl/data_ram.sv
// Word-addressed data memory for the MEM stage: synchronous write, combinational
// read, synchronous reset that clears the whole array in a single edge.
module data_ram #(
  parameter int ADDR_W = data_ram_pkg::RAM_ADDR_W,
  parameter int DATA_W = data_ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the array is built from flops rather than a RAM macro precisely so that
  // reset can clear every word on one edge; reset takes priority over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[addr] <= din;
    end
  end

  // Zero-latency read: a same-address write shows up only after the edge.
  assign dout = r_mem[addr];

endmodule : data_ram

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: directed steps from the block's test plan,
// then randomized traffic checked against a plain array reference model.
module tb_data_ram;
  import data_ram_pkg::*;

  localparam int DEPTH = 2 ** RAM_ADDR_W;

  logic   clk;
  logic   reset;
  logic   we;
  waddr_t addr;
  word_t  din;
  word_t  dout;

  word_t model [DEPTH];
  int    n_checks;
  int    n_errors;

  data_ram #(
    .ADDR_W(RAM_ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model applies the same rules the memory must obey.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else if (we) begin
      model[addr] = din;
    end
    #1;
  endtask

  task automatic read_check(input string tag, input int a);
    addr = waddr_t'(a);
    #1;
    check(tag, dout, model[a]);
  endtask

  task automatic write_word(input int a, input word_t d);
    we   = 1'b1;
    addr = waddr_t'(a);
    din  = d;
    tick();
    we   = 1'b0;
  endtask

  initial begin
    int    bad_words;
    int    ra;
    word_t old_word;

    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    reset = 1'b0;
    we    = 1'b0;
    addr  = '0;
    din   = '0;
    @(negedge clk);

    // Reset then read
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read_check("reset_addr0", 0);
    read_check("reset_addr3", 3);
    read_check("reset_addr1023", 1023);
    check("model_reset_0", model[0], 32'h0000_0000);

    // Write and read back
    write_word(4, 32'h0000_001F);
    write_word(1, 32'h0000_0010);
    addr = 10'd4; #1; check("wr_addr4", dout, 32'h0000_001F);
    addr = 10'd3; #1; check("wr_addr3", dout, 32'h0000_0000);
    addr = 10'd1; #1; check("wr_addr1", dout, 32'h0000_0010);

    // Write disabled over several edges
    we   = 1'b0;
    addr = 10'd4;
    din  = 32'hDEAD_BEEF;
    repeat (4) tick();
    check("we0_addr4", dout, 32'h0000_001F);

    // Boundary addresses
    write_word(0, 32'hAAAA_AAAA);
    write_word(1023, 32'h5555_5555);
    addr = 10'd0;    #1; check("bound_addr0", dout, 32'hAAAA_AAAA);
    addr = 10'd1023; #1; check("bound_addr1023", dout, 32'h5555_5555);
    addr = 10'd1;    #1; check("bound_addr1", dout, 32'h0000_0010);
    addr = 10'd1022; #1; check("bound_addr1022", dout, 32'h0000_0000);

    // Read during write on the same address
    write_word(7, 32'h1111_1111);
    we   = 1'b1;
    addr = 10'd7;
    din  = 32'h2222_2222;
    #1;
    check("rdw_before_edge", dout, 32'h1111_1111);
    tick();
    check("rdw_after_edge", dout, 32'h2222_2222);
    we   = 1'b0;
    addr = 10'd4;
    #1;
    check("zero_latency_addr4", dout, 32'h0000_001F);

    // Reset wins over a simultaneous write
    reset = 1'b1;
    we    = 1'b1;
    addr  = 10'd4;
    din   = 32'h1234_5678;
    tick();
    reset = 1'b0;
    we    = 1'b0;
    check("rst_prio_addr4", dout, 32'h0000_0000);
    addr = 10'd1;    #1; check("rst_prio_addr1", dout, 32'h0000_0000);
    addr = 10'd0;    #1; check("rst_prio_addr0", dout, 32'h0000_0000);
    addr = 10'd1023; #1; check("rst_prio_addr1023", dout, 32'h0000_0000);
    addr = 10'd7;    #1; check("rst_prio_addr7", dout, 32'h0000_0000);

    // Randomized traffic, concentrated on a small window so reads hit written words
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      we    = ($urandom_range(0, 1) == 1);
      ra    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                          : int'($urandom_range(0, 15));
      addr  = waddr_t'(ra);
      din   = word_t'($urandom);
      #1;
      old_word = model[ra];
      check("rand_pre_edge", dout, old_word);
      tick();
      check("rand_post_edge", dout, model[ra]);
      reset = 1'b0;
      we    = 1'b0;
      ra    = int'($urandom_range(0, 15));
      addr  = waddr_t'(ra);
      #1;
      check("rand_read", dout, model[ra]);
    end

    // Full sweep: every word must match the model; one check summarises the sweep
    bad_words = 0;
    for (int i = 0; i < DEPTH; i++) begin
      addr = waddr_t'(i);
      #1;
      if (dout !== model[i]) bad_words++;
    end
    check("sweep_bad_words", word_t'(bad_words), 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_data_ram
